// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_mux_arbiter_if : four-source valid/ready bundle plus one output channel  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_last,
    output in_data0,
    output in_data1,
    output in_data2,
    output in_data3,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_data0,
    input  in_data1,
    input  in_data2,
    input  in_data3,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_sel
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_mux_arbiter : round-robin 4:1 mux arbiter with burst lock and out stage  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int c_N_PAIRS = WIDTH / 2;

  typedef enum logic [0:0] {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [1:0]       r_lock_sel;
  logic [1:0]       w_lock_sel_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [1:0]       r_out_sel;

  logic             w_can_load;
  logic             w_free_any;
  logic [1:0]       w_free_sel;
  logic             w_gnt_any;
  logic [1:0]       w_gnt_sel;
  logic [3:0]       w_in_ready;
  logic             w_accept;
  logic             w_gnt_last;
  logic [WIDTH-1:0] w_mux_data;

  assign w_can_load = ~r_out_valid | bus.out_ready;

  // Scan from ptr+3 down to ptr so the lowest rotated offset wins.
  always_comb begin
    w_free_any = 1'b0;
    w_free_sel = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_valid[r_ptr + 2'(k)]) begin
        w_free_any = 1'b1;
        w_free_sel = r_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    w_gnt_any = w_free_any;
    w_gnt_sel = w_free_sel;
    if (r_state == ST_LOCKED) begin
      w_gnt_any = 1'b1;
      w_gnt_sel = r_lock_sel;
    end
  end

  always_comb begin
    w_in_ready = 4'b0000;
    if (w_gnt_any && w_can_load && !rst) begin
      w_in_ready[w_gnt_sel] = 1'b1;
    end
  end

  assign w_accept   = |(w_in_ready & bus.in_valid);
  assign w_gnt_last = bus.in_last[w_gnt_sel];

  generate
    if (WIDTH % 2 == 0) begin : g_pair_mux
      for (genvar j = 0; j < c_N_PAIRS; j++) begin : g_slice
        logic [1:0] w_slice;
        always_comb begin
          w_slice = bus.in_data0[2*j +: 2];
          case (w_gnt_sel)
            2'd1:    w_slice = bus.in_data1[2*j +: 2];
            2'd2:    w_slice = bus.in_data2[2*j +: 2];
            2'd3:    w_slice = bus.in_data3[2*j +: 2];
            default: w_slice = bus.in_data0[2*j +: 2];
          endcase
        end
        assign w_mux_data[2*j +: 2] = w_slice;
      end
    end else begin : g_bit_mux
      always_comb begin
        w_mux_data = bus.in_data0;
        case (w_gnt_sel)
          2'd1:    w_mux_data = bus.in_data1;
          2'd2:    w_mux_data = bus.in_data2;
          2'd3:    w_mux_data = bus.in_data3;
          default: w_mux_data = bus.in_data0;
        endcase
      end
    end
  endgenerate

  // A non-last beat pins the grant until that same source delivers its last beat.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_sel_nxt = r_lock_sel;
    if (w_accept) begin
      if (w_gnt_last) begin
        w_state_nxt = ST_FREE;
        w_ptr_nxt   = w_gnt_sel + 2'd1;
      end else begin
        w_state_nxt    = ST_LOCKED;
        w_lock_sel_nxt = w_gnt_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FREE;
      r_ptr      <= 2'd0;
      r_lock_sel <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_sel <= w_lock_sel_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 2'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_last  <= w_gnt_last;
      r_out_sel   <= w_gnt_sel;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_sel   = r_out_sel;
endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_rr_mux_arbiter : directed vectors plus per-cycle reference model        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_rr_mux_arbiter;
  localparam int c_W = 4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  rr_mux_arbiter_if #(.WIDTH(c_W)) bus ();

  rr_mux_arbiter #(.WIDTH(c_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [c_W-1:0] data_of(input int g);
    case (g)
      0:       return bus.in_data0;
      1:       return bus.in_data1;
      2:       return bus.in_data2;
      default: return bus.in_data3;
    endcase
  endfunction

  // Reference model: state as it will be after the coming rising edge
  bit           m_known;
  int           m_ptr;
  bit           m_locked;
  int           m_lock_sel;
  bit           m_ov;
  logic [c_W-1:0] m_od;
  bit           m_ol;
  int           m_os;

  always @(negedge clk) begin : p_model
    logic [3:0] exp_rdy;
    int         g;
    bit         has_g;
    bit         can_load;
    exp_rdy  = 4'b0000;
    has_g    = 1'b0;
    g        = 0;
    can_load = 1'b0;
    if (!rst && m_known) begin
      can_load = !m_ov || bus.out_ready;
      if (m_locked) begin
        has_g = 1'b1;
        g     = m_lock_sel;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!has_g && bus.in_valid[(m_ptr + k) % 4]) begin
            has_g = 1'b1;
            g     = (m_ptr + k) % 4;
          end
        end
      end
      if (has_g && can_load) exp_rdy[g] = 1'b1;
    end
    check("model_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (m_known) begin
      check("model_out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("model_out_data",  32'(bus.out_data),  32'(m_od));
      check("model_out_last",  32'(bus.out_last),  32'(m_ol));
      check("model_out_sel",   32'(bus.out_sel),   32'(m_os));
    end
    if (rst) begin
      m_known    = 1'b1;
      m_ptr      = 0;
      m_locked   = 1'b0;
      m_lock_sel = 0;
      m_ov       = 1'b0;
      m_od       = '0;
      m_ol       = 1'b0;
      m_os       = 0;
    end else if (m_known) begin
      if (has_g && can_load && bus.in_valid[g]) begin
        m_ov = 1'b1;
        m_od = data_of(g);
        m_ol = bus.in_last[g];
        m_os = g;
        if (bus.in_last[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % 4;
        end else begin
          m_locked   = 1'b1;
          m_lock_sel = g;
        end
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Apply one cycle of inputs, pin in_ready, then step past the edge.
  task automatic beat(input logic [3:0] v, input logic [3:0] l, input logic r, input logic [3:0] exp_rdy);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    check("lit_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input logic v, input logic [1:0] s, input logic [c_W-1:0] d, input logic l);
    check("lit_out_valid", 32'(bus.out_valid), 32'(v));
    check("lit_out_sel",   32'(bus.out_sel),   32'(s));
    check("lit_out_data",  32'(bus.out_data),  32'(d));
    check("lit_out_last",  32'(bus.out_last),  32'(l));
  endtask

  task automatic do_reset(input logic [3:0] v, input int n);
    rst           = 1'b1;
    bus.in_valid  = v;
    bus.in_last   = 4'hf;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic set_data();
    bus.in_data0 = 4'ha;
    bus.in_data1 = 4'hb;
    bus.in_data2 = 4'hc;
    bus.in_data3 = 4'hd;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_known = 1'b0;
    set_data();

    // Reset with all sources requesting
    do_reset(4'hf, 2);

    // Rotation of single-beat bursts, drain and load every cycle
    beat(4'hf, 4'hf, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'hf, 4'hf, 1'b1, 4'b0010); chk_out(1'b1, 2'd1, 4'hb, 1'b1);
    beat(4'hf, 4'hf, 1'b1, 4'b0100); chk_out(1'b1, 2'd2, 4'hc, 1'b1);
    beat(4'hf, 4'hf, 1'b1, 4'b1000); chk_out(1'b1, 2'd3, 4'hd, 1'b1);
    beat(4'hf, 4'hf, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    do_reset(4'h0, 1);

    // Three-beat burst from source 1 with source 2 waiting
    bus.in_data1 = 4'h1;
    beat(4'b0110, 4'b0000, 1'b1, 4'b0010); chk_out(1'b1, 2'd1, 4'h1, 1'b0);
    bus.in_data1 = 4'h2;
    beat(4'b0110, 4'b0000, 1'b1, 4'b0010); chk_out(1'b1, 2'd1, 4'h2, 1'b0);
    bus.in_data1 = 4'h3;
    beat(4'b0110, 4'b0010, 1'b1, 4'b0010); chk_out(1'b1, 2'd1, 4'h3, 1'b1);
    beat(4'b0111, 4'b0100, 1'b1, 4'b0100); chk_out(1'b1, 2'd2, 4'hc, 1'b1);
    beat(4'b0001, 4'b0001, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    set_data();
    do_reset(4'h0, 1);

    // Lock held through an idle gap on source 0 while source 3 waits
    beat(4'b1001, 4'b0000, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b0);
    beat(4'b1000, 4'b0000, 1'b1, 4'b0001); chk_out(1'b0, 2'd0, 4'ha, 1'b0);
    beat(4'b1000, 4'b0000, 1'b1, 4'b0001); chk_out(1'b0, 2'd0, 4'ha, 1'b0);
    beat(4'b1001, 4'b0001, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b1000, 4'b0000, 1'b1, 4'b1000); chk_out(1'b1, 2'd3, 4'hd, 1'b0);
    do_reset(4'h0, 1);

    // Backpressure for three cycles, then back-to-back transfers
    beat(4'b0011, 4'b0011, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b0011, 4'b0011, 1'b0, 4'b0000); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b0011, 4'b0011, 1'b0, 4'b0000); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b0011, 4'b0011, 1'b0, 4'b0000); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b0011, 4'b0011, 1'b1, 4'b0010); chk_out(1'b1, 2'd1, 4'hb, 1'b1);
    beat(4'b0011, 4'b0011, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);
    beat(4'b0000, 4'b0000, 1'b1, 4'b0000); chk_out(1'b0, 2'd0, 4'ha, 1'b1);
    do_reset(4'h0, 1);

    // Reset in the middle of a source-2 burst
    beat(4'b0100, 4'b0000, 1'b1, 4'b0100); chk_out(1'b1, 2'd2, 4'hc, 1'b0);
    do_reset(4'b0101, 1);
    beat(4'b0101, 4'b0101, 1'b1, 4'b0001); chk_out(1'b1, 2'd0, 4'ha, 1'b1);

    beat(4'b0000, 4'b0000, 1'b1, 4'b0000);
    beat(4'b0000, 4'b0000, 1'b1, 4'b0000);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
